reg_image_deserializer: RTL and testbench
=========================================

# reg_image_deserializer

Receives the 96-bit serial stream that the register file emits on `serial_out`/`start`. It rebuilds the 12×8 register image (B, C, D, E, H, L, W, Z, PCh, PCl, SPh, SPl) into a committed snapshot buffer. Debug and observation logic reads that buffer byte by byte. It sits directly downstream of the register file's serializer, in the serializer's clock domain, and reports frame completion, image changes and framing errors.

## Interface

- `WIDTH`, 8, bits per register element
- `DEPTH`, 12, elements per frame; frame length is WIDTH*DEPTH = 96 bits
- `AW`, 4, read address width, $clog2(DEPTH)

- `clk`  in  1  the only clock; same clock that drives the serializer
- `rst`  in  1  synchronous, active-high reset
- `serial_in`  in  1  serial data bit, one per clock
- `start`  in  1  high for exactly one cycle, coincident with bit 0 of a frame
- `rd_addr`  in  AW  snapshot element index
- `rd_data`  out  WIDTH  committed snapshot element at `rd_addr` (combinational)
- `frame_valid`  out  1  high once at least one complete frame is committed
- `frame_done`  out  1  one-cycle pulse after each commit
- `changed`  out  1  one-cycle pulse with `frame_done` when the new image differs from the previous one
- `sync_err`  out  1  sticky framing-error flag
- `err_clr`  in  1  clears `sync_err`
- `frame_cnt`  out  8  count of committed frames, wraps modulo 256

## Operation

- Frame format:
  - Element 0 first, element DEPTH-1 last.
  - Within each element, MSB first.
  - Bit k of the frame is element k/WIDTH, bit WIDTH-1-(k mod WIDTH).
- States:
  - IDLE: waiting for `start`.
  - SHIFT: receiving bits. Bit counter `cnt` holds bits received (1..95).
- IDLE transitions:
  - `start`=1: sample `serial_in` into the shift register, `cnt`<=1, go to SHIFT.
  - `start`=0: `serial_in` ignored.
- SHIFT, `start`=0 and `cnt`<95: shift in the bit, `cnt`++.
- SHIFT, `start`=0 and `cnt`==95 (last bit):
  - Commit `{shift[94:0], serial_in}` to the snapshot.
  - Pulse `frame_done`, increment `frame_cnt`, set `frame_valid`.
  - Return to IDLE.
- SHIFT, `start`=1 (premature start):
  - Set `sync_err` and discard the partial frame. The snapshot is unchanged and there is no `frame_done`.
  - Treat this bit as bit 0 of a new frame: `cnt`<=1, stay in SHIFT.
- Back-to-back frames: `start` may arrive in the cycle right after the last bit. IDLE accepts it with no gap.
- `changed`: the 96-bit compare of the new image against the snapshot's contents before the commit. The first frame after reset is compared against all-zero.
- `rd_addr` >= DEPTH: `rd_data`=0.
- `sync_err`: if `err_clr` and a new error occur in the same cycle, the set wins.

## Timing

- Reset values:
  - FSM=IDLE, `cnt`=0, shift register=0, snapshot=all 0.
  - `rd_data`=0, `frame_valid`=0, `frame_done`=0, `changed`=0, `sync_err`=0, `frame_cnt`=0.
- Reset asserted mid-frame: the partial frame is lost. Bits arriving while `rst`=1 are ignored, including a `start` during reset. The next `start` after reset deasserts begins a fresh frame.
- Latency: the last bit is sampled at edge E. In the cycle after E:
  - `frame_done`/`changed` are high.
  - `rd_data` already shows the new image.
  - `frame_cnt` is already incremented.
- The snapshot never shows a mix of two frames. It updates only at commit, in a single edge.
- `frame_done` and `changed` are registered and high for exactly one cycle.

## Test plan

- Single frame B..SPl = 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0,0x01,0x23,0x45,0x67 -> `frame_done`/`changed` pulse one cycle after bit 95; `rd_data`@0=0x12, @11=0x67; `frame_cnt`=1; `frame_valid`=1.
- Same image sent twice back-to-back with no gap -> two `frame_done` pulses 96 cycles apart; `changed` only on the first; `frame_cnt`=2.
- All-zero first frame -> `frame_done`=1, `changed`=0. Second frame with only element 5 = 0x01 -> `changed`=1, `rd_data`@5=0x01.
- `start` re-asserted at bit 40 of a frame -> `sync_err`=1, no commit at the old frame's end; the new frame commits 96 cycles after the second `start`. Then `err_clr` -> `sync_err`=0. `err_clr` coincident with another premature `start` -> `sync_err` stays 1.
- `rst` pulsed at bit 60 -> all outputs at reset values; trailing bits with no new `start` produce no commit; the next full frame commits correctly.
- `rd_addr`=12..15 -> `rd_data`=0. 256 frames -> `frame_cnt` wraps 255->0 while `frame_valid` stays 1.

Source files
------------

// File: rtl/reg_image_deserializer_if.sv
// Bundle of the serial input, snapshot read port and status flags of the
// register image deserializer.
interface reg_image_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             serial_in;
    logic             start;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             frame_valid;
    logic             frame_done;
    logic             changed;
    logic             sync_err;
    logic             err_clr;
    logic [7:0]       frame_cnt;

    // Source side: drives the serial stream and reads the snapshot.
    modport master (
        output serial_in, start, rd_addr, err_clr,
        input  rd_data, frame_valid, frame_done, changed, sync_err, frame_cnt
    );

    // Deserializer side.
    modport slave (
        input  serial_in, start, rd_addr, err_clr,
        output rd_data, frame_valid, frame_done, changed, sync_err, frame_cnt
    );
endinterface

// File: rtl/reg_image_deserializer.sv
// Rebuilds the DEPTH x WIDTH register image from the serializer's bit stream
// and holds it in a snapshot that only ever changes on a whole-frame commit.
module reg_image_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input logic                    clk,
    input logic                    rst,
    reg_image_deserializer_if.slave bus
);
    localparam int FRAME_W = WIDTH * DEPTH;
    localparam int CW      = $clog2(FRAME_W);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic               shift_en;
    logic               commit;
    logic               err_set;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] image_next;
    logic [FRAME_W-1:0] snap;
    logic               frame_valid;
    logic               frame_done;
    logic               changed;
    logic               sync_err;
    logic [7:0]         frame_cnt;
    logic [WIDTH-1:0]   rd_data;

    // The completed image includes the bit arriving in the commit cycle.
    assign image_next = {shift_reg[FRAME_W-2:0], bus.serial_in};

    // State and bit counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Framing decisions: accept, shift, commit, or restart on an early start.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_en   = 1'b0;
        commit     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shift_en   = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bus.start) begin
                    // Partial frame is dropped; this bit opens a new frame.
                    err_set  = 1'b1;
                    cnt_next = CW'(1);
                end else if (cnt == LAST) begin
                    commit     = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Serial-to-parallel shift register, MSB of the frame enters first.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= image_next;
        end
    end

    // Snapshot commit plus registered completion/change pulses and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap        <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            changed     <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_done <= commit;
            changed    <= commit && (image_next != snap);
            if (commit) begin
                snap        <= image_next;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    // Sticky framing error; a new error in the clear cycle keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (err_set) begin
            sync_err <= 1'b1;
        end else if (bus.err_clr) begin
            sync_err <= 1'b0;
        end
    end

    // Combinational element read; element 0 occupies the top of the snapshot.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                rd_data = snap[FRAME_W-1-i*WIDTH -: WIDTH];
            end
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_done  = frame_done;
    assign bus.changed     = changed;
    assign bus.sync_err    = sync_err;
    assign bus.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_reg_image_deserializer.sv
// Bench for reg_image_deserializer: directed frame sequences with a
// scoreboard of expected commits checked whenever frame_done pulses.
module tb_reg_image_deserializer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int FW    = WIDTH * DEPTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_image_deserializer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    reg_image_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       chg;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [FW-1:0] model_snap = '0;
    logic [7:0]  model_cnt  = 8'd0;
    logic        prev_done  = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Commit monitor: every frame_done must match the front of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.changed) chk("changed_with_done", FW'(bus.frame_done), FW'(1));
        if (bus.frame_done) begin
            chk("done_single_cycle", FW'(prev_done), FW'(0));
            chk("commit_expected", FW'(sb.size() != 0), FW'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("commit_cycle", FW'(cyc), FW'(e.cyc));
                chk("changed", FW'(bus.changed), FW'(e.chg));
                chk("frame_cnt", FW'(bus.frame_cnt), FW'(e.cnt));
                chk("frame_valid", FW'(bus.frame_valid), FW'(1));
            end
        end
        prev_done <= bus.frame_done;
    end

    function automatic logic [WIDTH-1:0] exp_elem(input int a);
        if (a >= DEPTH) return '0;
        return model_snap[FW-1-a*WIDTH -: WIDTH];
    endfunction

    task automatic drive(input logic st, input logic b);
        bus.start     = st;
        bus.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.start     = 1'b0;
        bus.serial_in = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] img, input logic clr_first);
        exp_t e;
        e.chg      = (img != model_snap);
        model_snap = img;
        model_cnt  = model_cnt + 8'd1;
        e.cnt      = model_cnt;
        e.cyc      = cyc + FW;
        sb.push_back(e);
        for (int k = 0; k < FW; k++) begin
            bus.err_clr = clr_first && (k == 0);
            drive(k == 0, img[FW-1-k]);
        end
        quiet();
    endtask

    task automatic send_partial(input logic [FW-1:0] img, input int n);
        for (int k = 0; k < n; k++) drive(k == 0, img[FW-1-k]);
        quiet();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)));
        quiet();
    endtask

    task automatic check_rd(input int a);
        bus.rd_addr = AW'(a);
        @(negedge clk);
        chk($sformatf("rd_data@%0d", a), FW'(bus.rd_data), FW'(exp_elem(a)));
    endtask

    task automatic check_all_rd();
        for (int a = 0; a < 16; a++) check_rd(a);
    endtask

    task automatic do_reset();
        chk("scoreboard_drained", FW'(sb.size()), FW'(0));
        sb.delete();
        rst = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        rst = 1'b0;
        quiet();
        model_snap = '0;
        model_cnt  = 8'd0;
        chk("rst_frame_valid", FW'(bus.frame_valid), FW'(0));
        chk("rst_frame_done", FW'(bus.frame_done), FW'(0));
        chk("rst_changed", FW'(bus.changed), FW'(0));
        chk("rst_sync_err", FW'(bus.sync_err), FW'(0));
        chk("rst_frame_cnt", FW'(bus.frame_cnt), FW'(0));
        check_rd(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] img_a;
        logic [FW-1:0] img_b;
        rst         = 1'b1;
        bus.rd_addr = '0;
        quiet();
        img_a = 96'h123456789ABCDEF001234567;
        img_b = 96'hA5C3_0F1E_7788_9911_2233_4455;

        // Single frame
        do_reset();
        idle(3);
        send_frame(img_a, 1'b0);
        chk("single_frame_cnt", FW'(bus.frame_cnt), FW'(1));
        chk("single_frame_valid", FW'(bus.frame_valid), FW'(1));
        check_all_rd();

        // Same image twice back-to-back
        do_reset();
        send_frame(img_b, 1'b0);
        send_frame(img_b, 1'b0);
        chk("b2b_frame_cnt", FW'(bus.frame_cnt), FW'(2));
        check_rd(0);
        check_rd(11);

        // All-zero first frame, then only element 5 set
        do_reset();
        send_frame('0, 1'b0);
        idle(2);
        send_frame(96'h1 << 48, 1'b0);
        check_rd(5);
        check_rd(4);

        // Premature start at bit 40, then error clear, then clear colliding with error
        do_reset();
        send_frame(img_a, 1'b0);
        send_partial(img_b, 40);
        send_frame(~img_a, 1'b0);
        chk("premature_sync_err", FW'(bus.sync_err), FW'(1));
        check_all_rd();
        bus.err_clr = 1'b1;
        drive(1'b0, 1'b0);
        quiet();
        chk("err_clr_sync_err", FW'(bus.sync_err), FW'(0));
        send_partial(img_b, 10);
        send_frame(img_b, 1'b1);
        chk("set_beats_clr_sync_err", FW'(bus.sync_err), FW'(1));
        check_rd(3);

        // Reset in the middle of a frame
        send_partial(img_a, 60);
        do_reset();
        idle(36);
        idle(4);
        chk("no_commit_after_rst", FW'(bus.frame_cnt), FW'(0));
        send_frame(img_a ^ img_b, 1'b0);
        check_all_rd();

        // 256 frames wrap the counter
        for (int f = 0; f < 256; f++) begin
            send_frame({$urandom, $urandom, $urandom}, 1'b0);
        end
        idle(3);
        chk("wrap_frame_cnt", FW'(bus.frame_cnt), FW'(model_cnt));
        chk("wrap_frame_valid", FW'(bus.frame_valid), FW'(1));
        chk("final_scoreboard_empty", FW'(sb.size()), FW'(0));
        check_rd(7);
        check_rd(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
